ecc_io_ctrl: RTL and testbench
==============================

Name: ecc_io_ctrl

Overview:
Byte-serial front end for the ECC scalar-multiply core.
- Accepts a mode byte followed by the five operands (a, p, x, y, n) on an 8-bit valid/ready stream and assembles them into MAX_BITS-wide registers.
- Fires a one-cycle start to the core, waits for its finish pulse, then captures result x/y.
- Streams the result back out as bytes on a second valid/ready stream.

Parameters:
MAX_BITS, 128, operand/result width; must match the core.
BYTE_W, 8, stream data width; fixed at 8.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
i_in_data  in  8  input stream byte
i_in_valid  in  1  input byte valid
o_in_ready  out  1  block accepts a byte this cycle
o_out_data  out  8  output stream byte
o_out_valid  out  1  output byte valid
i_out_ready  in  1  sink accepts the byte this cycle
o_busy  out  1  high from mode-byte accept until the last output byte is accepted
o_core_start  out  1  one-cycle start pulse to the core
o_mode  out  2  operand size to the core: 0=16, 1=32, 2=64, 3=128 bits
o_a, o_p, o_x, o_y, o_n  out  MAX_BITS each  operands to the core, held stable while busy
i_core_finish  in  1  core done, single-cycle pulse
i_core_x, i_core_y  in  MAX_BITS each  core result, valid when i_core_finish=1

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset state: all outputs 0, state IDLE, all registers and counters 0.
- Handshake: a byte transfers on a cycle where valid and ready are both high. o_out_data is stable while o_out_valid=1 and i_out_ready=0.
- nbytes is derived from mode: 2, 4, 8 or 16.
- IDLE:
  - o_in_ready=1.
  - On transfer: o_mode ← i_in_data[1:0]; bits [7:2] are ignored.
  - o_a..o_n cleared to 0 on the same cycle; byte counter ← nbytes-1; operand index ← 0.
  - Go to LOAD; o_busy=1 from the next cycle.
- LOAD:
  - o_in_ready=1.
  - Each transfer: selected operand ← {operand[MAX_BITS-9:0], i_in_data}. Bytes arrive MSB first, so the value is right-aligned and zero-extended.
  - Counter decrements per byte. At 0, advance operand index (a→p→x→y→n) and reload the counter.
  - After the last byte of n, go to START.
- START:
  - o_core_start=1 for exactly one cycle (the cycle after the last byte is accepted); o_in_ready=0.
  - Go to WAIT.
- WAIT:
  - o_in_ready=0; input bytes are not consumed.
  - On i_core_finish: latch i_core_x/i_core_y into result registers, output index ← 0, go to OUT.
  - i_core_finish in any state other than WAIT is ignored.
- OUT:
  - o_out_valid=1, first byte valid the cycle after finish is sampled.
  - Sequence: result x MSB-first (nbytes bytes), then result y MSB-first (nbytes bytes), 2*nbytes in total.
  - Index advances only on transfer. After the final transfer: o_out_valid=0, o_busy=0, go to IDLE.
- The next mode byte can be accepted the cycle after return to IDLE.
- Operands and o_mode hold their values until the next mode byte; the core samples them continuously.
- No timeout; a hung core keeps the block in WAIT until rst.
- Reset mid-operation: immediate return to IDLE with all outputs 0; any partial operand is discarded.
- Total input bytes per job = 1 + 5*nbytes.
- Widths: byte counter 4 bits, operand index 3 bits, output index 5 bits.

Decomposition:
- The mode encoding (BITS16/32/64/128), MAX_BITS and the state encodings belong in the shared ECCDefine header already used by the core.
- One natural sub-module, ecc_byte_ser: a 2*MAX_BITS result holder plus byte selector with valid/ready.
- Deserialising stays inline in ecc_io_ctrl.

Test Plan:
- 16-bit load: bytes 00, 00 02, 00 11, 00 05, 00 01, 00 07 → o_mode=0, o_a=0x2, o_p=0x11, o_x=0x5, o_y=0x1, o_n=0x7, upper bits 0; o_core_start high exactly one cycle, one cycle after the last byte.
- Result stream: stub core pulses finish 10 cycles after start with x=0x000A, y=0x0010 → output bytes 00, 0A, 00, 10. With i_out_ready toggled 1-0-1-0, each byte is held until accepted; o_busy drops after the 4th.
- 128-bit job: mode byte 03 plus 80 operand bytes (n = 0x01..0x10) → o_n=0x0102…10; exactly 32 output bytes; o_in_ready=0 for the whole of START/WAIT/OUT.
- Back-pressure and idle gaps: i_in_valid low every other cycle during load → identical operands. Bytes driven during WAIT are not accepted; a stray i_core_finish during LOAD is ignored.
- Reset mid-load: rst asserted after 5 accepted bytes → all outputs 0 asynchronously. A fresh 16-bit job afterwards produces correct operands with no residue.
- Mode byte 0xFE → o_mode=2 (64-bit); 40 operand bytes expected, then start.

Source files
------------

// File: rtl/ecc_io_ctrl_pkg.sv
// Shared definitions for the ECC scalar-multiply byte-stream front end:
// widths, mode encoding, controller states and mode-to-length helpers.
package ecc_io_ctrl_pkg;

   localparam int ECC_MAX_BITS = 128;
   localparam int ECC_BYTE_W   = 8;

   typedef enum logic [1:0] {
      BITS16  = 2'd0,
      BITS32  = 2'd1,
      BITS64  = 2'd2,
      BITS128 = 2'd3
   } ecc_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_OUT   = 3'd4
   } ecc_io_state_e;

   function automatic logic [4:0] mode_nbytes(input logic [1:0] mode);
      case (mode)
         BITS16:  return 5'd2;
         BITS32:  return 5'd4;
         BITS64:  return 5'd8;
         BITS128: return 5'd16;
         default: return 5'd2;
      endcase
   endfunction

   // Byte-counter reload value (nbytes-1) for a given mode.
   function automatic logic [3:0] mode_last(input logic [1:0] mode);
      case (mode)
         BITS16:  return 4'd1;
         BITS32:  return 4'd3;
         BITS64:  return 4'd7;
         BITS128: return 4'd15;
         default: return 4'd1;
      endcase
   endfunction

endpackage

// File: rtl/ecc_byte_ser.sv
// Result holder for the core's x/y pair; streams nbytes of x then nbytes of y,
// MSB first, over a valid/ready byte interface.
module ecc_byte_ser
   import ecc_io_ctrl_pkg::*;
#(
   parameter int MAX_BITS = ECC_MAX_BITS,
   parameter int BYTE_W   = ECC_BYTE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [MAX_BITS-1:0] i_res_x,
   input  logic [MAX_BITS-1:0] i_res_y,
   input  logic [4:0]          i_nbytes,
   output logic [BYTE_W-1:0]   o_data,
   output logic                o_valid,
   input  logic                i_ready,
   output logic                o_last
);

   logic [2*MAX_BITS-1:0] r_res;
   logic [4:0]            r_idx;
   logic [BYTE_W-1:0]     r_data;
   logic                  r_valid;
   logic                  w_xfer;
   logic [4:0]            w_last_idx;

   // x sits in the upper half of res; idx counts bytes in stream order.
   function automatic logic [BYTE_W-1:0] sel_byte(input logic [2*MAX_BITS-1:0] res,
                                                  input logic [4:0] nb,
                                                  input logic [4:0] idx);
      logic [2*MAX_BITS-1:0] sh;
      int                    pos;
      if (idx < nb) begin
         pos = int'(nb) - int'(idx) - 1;
         sh  = res >> (MAX_BITS + BYTE_W * pos);
      end else begin
         pos = 2 * int'(nb) - int'(idx) - 1;
         sh  = res >> (BYTE_W * pos);
      end
      return sh[BYTE_W-1:0];
   endfunction

   assign w_xfer     = r_valid & i_ready;
   assign w_last_idx = (i_nbytes << 1) - 5'd1;
   assign o_last     = w_xfer & (r_idx == w_last_idx);
   assign o_data     = r_data;
   assign o_valid    = r_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res   <= '0;
         r_idx   <= 5'd0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_res   <= {i_res_x, i_res_y};
         r_idx   <= 5'd0;
         r_data  <= sel_byte({i_res_x, i_res_y}, i_nbytes, 5'd0);
         r_valid <= 1'b1;
      end else if (w_xfer) begin
         if (r_idx == w_last_idx) begin
            r_idx   <= 5'd0;
            r_data  <= '0;
            r_valid <= 1'b0;
         end else begin
            r_idx   <= r_idx + 5'd1;
            r_data  <= sel_byte(r_res, i_nbytes, r_idx + 5'd1);
         end
      end
   end

endmodule

// File: rtl/ecc_io_ctrl.sv
// Byte-serial front end for the ECC scalar-multiply core: deserialises mode and
// operands, kicks the core, and streams the x/y result back out.
module ecc_io_ctrl
   import ecc_io_ctrl_pkg::*;
#(
   parameter int MAX_BITS = ECC_MAX_BITS,
   parameter int BYTE_W   = ECC_BYTE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BYTE_W-1:0]   i_in_data,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   output logic [BYTE_W-1:0]   o_out_data,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic                o_busy,
   output logic                o_core_start,
   output logic [1:0]          o_mode,
   output logic [MAX_BITS-1:0] o_a,
   output logic [MAX_BITS-1:0] o_p,
   output logic [MAX_BITS-1:0] o_x,
   output logic [MAX_BITS-1:0] o_y,
   output logic [MAX_BITS-1:0] o_n,
   input  logic                i_core_finish,
   input  logic [MAX_BITS-1:0] i_core_x,
   input  logic [MAX_BITS-1:0] i_core_y
);

   ecc_io_state_e       r_state, w_next;
   logic [1:0]          r_mode;
   logic [3:0]          r_cnt;
   logic [2:0]          r_opi;
   logic [MAX_BITS-1:0] r_a, r_p, r_x, r_y, r_n;
   logic                r_in_ready, r_busy, r_core_start;
   logic                w_in_xfer, w_load_done, w_res_load, w_out_last;
   logic [4:0]          w_nbytes;

   function automatic logic [MAX_BITS-1:0] shift_in(input logic [MAX_BITS-1:0] v,
                                                    input logic [BYTE_W-1:0]   b);
      return {v[MAX_BITS-BYTE_W-1:0], b};
   endfunction

   assign w_in_xfer   = r_in_ready & i_in_valid;
   assign w_nbytes    = mode_nbytes(r_mode);
   assign w_load_done = w_in_xfer & (r_state == ST_LOAD) & (r_cnt == 4'd0) & (r_opi == 3'd4);
   assign w_res_load  = (r_state == ST_WAIT) & i_core_finish;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_in_xfer) w_next = ST_LOAD;   else w_next = ST_IDLE;
         ST_LOAD:  if (w_load_done) w_next = ST_START; else w_next = ST_LOAD;
         ST_START: w_next = ST_WAIT;
         ST_WAIT:  if (i_core_finish) w_next = ST_OUT; else w_next = ST_WAIT;
         ST_OUT:   if (w_out_last) w_next = ST_IDLE;   else w_next = ST_OUT;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Handshake/status outputs are registered from the next state so they track it exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_in_ready   <= 1'b0;
         r_busy       <= 1'b0;
         r_core_start <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_in_ready   <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
         r_busy       <= (w_next != ST_IDLE);
         r_core_start <= (w_next == ST_START);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode <= 2'd0;
         r_cnt  <= 4'd0;
         r_opi  <= 3'd0;
         r_a    <= '0;
         r_p    <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_n    <= '0;
      end else if (w_in_xfer && (r_state == ST_IDLE)) begin
         r_mode <= i_in_data[1:0];
         r_cnt  <= mode_last(i_in_data[1:0]);
         r_opi  <= 3'd0;
         r_a    <= '0;
         r_p    <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_n    <= '0;
      end else if (w_in_xfer && (r_state == ST_LOAD)) begin
         case (r_opi)
            3'd0:    r_a <= shift_in(r_a, i_in_data);
            3'd1:    r_p <= shift_in(r_p, i_in_data);
            3'd2:    r_x <= shift_in(r_x, i_in_data);
            3'd3:    r_y <= shift_in(r_y, i_in_data);
            default: r_n <= shift_in(r_n, i_in_data);
         endcase
         if (r_cnt == 4'd0) begin
            r_cnt <= mode_last(r_mode);
            r_opi <= r_opi + 3'd1;
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   ecc_byte_ser #(
      .MAX_BITS (MAX_BITS),
      .BYTE_W   (BYTE_W)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_res_load),
      .i_res_x  (i_core_x),
      .i_res_y  (i_core_y),
      .i_nbytes (w_nbytes),
      .o_data   (o_out_data),
      .o_valid  (o_out_valid),
      .i_ready  (i_out_ready),
      .o_last   (w_out_last)
   );

   assign o_in_ready   = r_in_ready;
   assign o_busy       = r_busy;
   assign o_core_start = r_core_start;
   assign o_mode       = r_mode;
   assign o_a          = r_a;
   assign o_p          = r_p;
   assign o_x          = r_x;
   assign o_y          = r_y;
   assign o_n          = r_n;

endmodule

// File: tb/tb_ecc_io_ctrl.sv
// Directed bench for ecc_io_ctrl: table of jobs plus reset-mid-load sequence.
module tb_ecc_io_ctrl;

   localparam int MB = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    i_in_data;
   logic          i_in_valid;
   logic          o_in_ready;
   logic [7:0]    o_out_data;
   logic          o_out_valid;
   logic          i_out_ready;
   logic          o_busy;
   logic          o_core_start;
   logic [1:0]    o_mode;
   logic [MB-1:0] o_a, o_p, o_x, o_y, o_n;
   logic          i_core_finish;
   logic [MB-1:0] i_core_x, i_core_y;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ecc_io_ctrl #(.MAX_BITS(MB), .BYTE_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_in_data     (i_in_data),
      .i_in_valid    (i_in_valid),
      .o_in_ready    (o_in_ready),
      .o_out_data    (o_out_data),
      .o_out_valid   (o_out_valid),
      .i_out_ready   (i_out_ready),
      .o_busy        (o_busy),
      .o_core_start  (o_core_start),
      .o_mode        (o_mode),
      .o_a           (o_a),
      .o_p           (o_p),
      .o_x           (o_x),
      .o_y           (o_y),
      .o_n           (o_n),
      .i_core_finish (i_core_finish),
      .i_core_x      (i_core_x),
      .i_core_y      (i_core_y)
   );

   typedef struct {
      logic [7:0]    mode_byte;
      logic [1:0]    exp_mode;
      logic [MB-1:0] a, p, x, y, n;
      logic [MB-1:0] rx, ry;
      bit            gap;
      bit            tog;
      bit            stray_in;
      bit            stray_fin;
   } job_t;

   job_t jobs[5];

   task automatic chk(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t;
      if (gap) @(negedge clk);
      i_in_data  = b;
      i_in_valid = 1'b1;
      t = 0;
      while (!o_in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("in_ready_for_byte", MB'(o_in_ready), MB'(1));
      @(negedge clk);
      i_in_valid = 1'b0;
   endtask

   task automatic send_operand(input logic [MB-1:0] v, input int nb, input bit gap);
      logic [MB-1:0] tmp;
      for (int k = 0; k < nb; k++) begin
         tmp = v >> ((nb - 1 - k) * 8);
         send_byte(tmp[7:0], gap);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_in_ready"},   MB'(o_in_ready),   '0);
      chk({tag, "_busy"},       MB'(o_busy),       '0);
      chk({tag, "_core_start"}, MB'(o_core_start), '0);
      chk({tag, "_out_valid"},  MB'(o_out_valid),  '0);
      chk({tag, "_out_data"},   MB'(o_out_data),   '0);
      chk({tag, "_mode"},       MB'(o_mode),       '0);
      chk({tag, "_a"}, o_a, '0);
      chk({tag, "_p"}, o_p, '0);
      chk({tag, "_x"}, o_x, '0);
      chk({tag, "_y"}, o_y, '0);
      chk({tag, "_n"}, o_n, '0);
   endtask

   task automatic run_job(input job_t j);
      int            nb, k, t;
      bit            rdy;
      logic [MB-1:0] tmp;
      nb = 2 << j.exp_mode;
      send_byte(j.mode_byte, j.gap);
      chk("busy_after_mode", MB'(o_busy), MB'(1));
      chk("mode", MB'(o_mode), MB'(j.exp_mode));
      if (j.stray_fin) begin
         i_core_x      = '1;
         i_core_y      = '1;
         i_core_finish = 1'b1;
         @(negedge clk);
         i_core_finish = 1'b0;
         i_core_x      = '0;
         i_core_y      = '0;
      end
      send_operand(j.a, nb, j.gap);
      send_operand(j.p, nb, j.gap);
      send_operand(j.x, nb, j.gap);
      send_operand(j.y, nb, j.gap);
      send_operand(j.n, nb, j.gap);
      chk("core_start_pulse", MB'(o_core_start), MB'(1));
      chk("in_ready_start", MB'(o_in_ready), '0);
      chk("op_a", o_a, j.a);
      chk("op_p", o_p, j.p);
      chk("op_x", o_x, j.x);
      chk("op_y", o_y, j.y);
      chk("op_n", o_n, j.n);
      @(negedge clk);
      chk("core_start_once", MB'(o_core_start), '0);
      for (int i = 0; i < 9; i++) begin
         if (j.stray_in) begin
            i_in_valid = 1'b1;
            i_in_data  = 8'hA5;
         end
         chk("in_ready_wait", MB'(o_in_ready), '0);
         chk("out_valid_wait", MB'(o_out_valid), '0);
         @(negedge clk);
      end
      i_core_x      = j.rx;
      i_core_y      = j.ry;
      i_core_finish = 1'b1;
      @(negedge clk);
      i_core_finish = 1'b0;
      i_core_x      = '0;
      i_core_y      = '0;
      i_in_valid    = 1'b0;
      k = 0;
      t = 0;
      while (k < 2 * nb && t < 400) begin
         rdy = j.tog ? (t % 2 == 0) : 1'b1;
         i_out_ready = rdy;
         if (o_out_valid) begin
            if (k < nb) tmp = j.rx >> ((nb - 1 - k) * 8);
            else        tmp = j.ry >> ((2 * nb - 1 - k) * 8);
            chk("out_byte", MB'(o_out_data), MB'(tmp[7:0]));
            chk("busy_out", MB'(o_busy), MB'(1));
            chk("in_ready_out", MB'(o_in_ready), '0);
            if (rdy) k++;
         end
         t++;
         @(negedge clk);
      end
      i_out_ready = 1'b0;
      chk("out_count", MB'(k), MB'(2 * nb));
      chk("valid_drop", MB'(o_out_valid), '0);
      chk("busy_drop", MB'(o_busy), '0);
      chk("in_ready_idle", MB'(o_in_ready), MB'(1));
      chk("mode_held", MB'(o_mode), MB'(j.exp_mode));
      chk("op_n_held", o_n, j.n);
   endtask

   initial begin
      rst           = 1'b1;
      i_in_data     = 8'h00;
      i_in_valid    = 1'b0;
      i_out_ready   = 1'b0;
      i_core_finish = 1'b0;
      i_core_x      = '0;
      i_core_y      = '0;

      jobs[0] = '{8'h00, 2'd0, 128'h2, 128'h11, 128'h5, 128'h1, 128'h7,
                  128'h000A, 128'h0010, 1'b0, 1'b1, 1'b0, 1'b0};
      jobs[1] = '{8'h03, 2'd3,
                  128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
                  128'hfffffffffffffffffffffffffffffffd,
                  128'h00112233445566778899aabbccddeeff,
                  128'h80000000000000000000000000000001,
                  128'h0102030405060708090a0b0c0d0e0f10,
                  128'hdeadbeef0123456789abcdef55aa33cc,
                  128'h00ff00ff11ee22dd33cc44bb55aa6699,
                  1'b0, 1'b0, 1'b0, 1'b0};
      jobs[2] = '{8'hFE, 2'd2,
                  128'h0123456789abcdef, 128'hffffffff00000001, 128'h00000000000000ab,
                  128'h8000000000000000, 128'h1122334455667788,
                  128'hcafef00d12345678, 128'h0badc0de00000001,
                  1'b1, 1'b1, 1'b1, 1'b0};
      jobs[3] = '{8'h01, 2'd1,
                  128'h89abcdef, 128'h00010001, 128'hdeadbeef, 128'h00000000, 128'h7fffffff,
                  128'h13579bdf, 128'h2468ace0,
                  1'b1, 1'b0, 1'b0, 1'b1};
      jobs[4] = '{8'h7C, 2'd0,
                  128'hffff, 128'h8001, 128'h00ff, 128'h1200, 128'h0034,
                  128'hffffffffffffffffffffffffffff1234,
                  128'h5555555555555555555555555555abcd,
                  1'b0, 1'b1, 1'b1, 1'b1};

      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("ready_after_reset", MB'(o_in_ready), MB'(1));
      chk("idle_not_busy", MB'(o_busy), '0);

      for (int i = 0; i < 5; i++) run_job(jobs[i]);

      // Reset after five accepted bytes of a 32-bit job.
      send_byte(8'h01, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      send_byte(8'h78, 1'b0);
      chk("partial_a", o_a, 128'h12345678);
      chk("partial_mode", MB'(o_mode), MB'(1));
      #2 rst = 1'b1;
      #1 check_zero_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_job(jobs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
